// File: rtl/vga_source_switcher.sv
// vga_source_switcher: debounced pushbutton requests a swap of the VGA mux
// source. The swap lands on a vsync start of the displayed source. Black is
// then forced for a few frames of the new source. A vsync timeout keeps
// the sequence moving when a source is dead.
module vga_source_switcher #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BLANK_FRAMES    = 2,
  parameter int unsigned VS_TIMEOUT      = 2000000,
  parameter bit          VS_ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic vgaV1,
  input  logic vgaV2,
  output logic sel,
  output logic blank,
  output logic busy,
  output logic req_pending
);

  localparam int  DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int  TO_W     = $clog2(VS_TIMEOUT + 1);
  localparam int  FRM_W    = $clog2(BLANK_FRAMES + 1);
  // Idle level of the vsync pins: high for low-active pulses.
  localparam logic VS_INACT = VS_ACTIVE_LOW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_BLANK   = 2'd2
  } state_t;

  logic             r_btn_s1, r_btn_s2, r_btn_db, r_req;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_v1_s1, r_v1_s2, r_v1_d;
  logic             r_v2_s1, r_v2_s2, r_v2_d;
  state_t           r_state, w_state_next;
  logic             r_sel, w_sel_next;
  logic             r_blank, w_blank_next;
  logic             r_pending, w_pending_next;
  logic [FRM_W-1:0] r_frm, w_frm_next;
  logic [TO_W-1:0]  r_to_cnt, w_to_next;
  logic             w_btn_diff, w_v1_start, w_v2_start;
  logic             w_vs_real, w_to_hit, w_vs_ev, w_busy;

  // Two-flop synchronisers plus one edge register per vsync input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_v1_s1  <= VS_INACT;
      r_v1_s2  <= VS_INACT;
      r_v1_d   <= VS_INACT;
      r_v2_s1  <= VS_INACT;
      r_v2_s2  <= VS_INACT;
      r_v2_d   <= VS_INACT;
    end else begin
      r_btn_s1 <= btn;
      r_btn_s2 <= r_btn_s1;
      r_v1_s1  <= vgaV1;
      r_v1_s2  <= r_v1_s1;
      r_v1_d   <= r_v1_s2;
      r_v2_s1  <= vgaV2;
      r_v2_s2  <= r_v2_s1;
      r_v2_d   <= r_v2_s2;
    end
  end

  assign w_btn_diff = (r_btn_s2 != r_btn_db);

  // Debounce: flip the accepted level after a run of differing samples;
  // a press (0->1 flip) emits a one-cycle request pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_db <= 1'b0;
      r_db_cnt <= '0;
      r_req    <= 1'b0;
    end else if (w_btn_diff) begin
      if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        r_btn_db <= ~r_btn_db;
        r_db_cnt <= '0;
        r_req    <= ~r_btn_db;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
        r_req    <= 1'b0;
      end
    end else begin
      r_db_cnt <= '0;
      r_req    <= 1'b0;
    end
  end

  assign w_v1_start = (r_v1_s2 != VS_INACT) && (r_v1_d == VS_INACT);
  assign w_v2_start = (r_v2_s2 != VS_INACT) && (r_v2_d == VS_INACT);
  assign w_vs_real  = r_sel ? w_v2_start : w_v1_start;
  assign w_busy     = (r_state != S_IDLE);
  assign w_to_hit   = w_busy && (r_to_cnt == TO_W'(VS_TIMEOUT - 1));
  assign w_vs_ev    = w_vs_real || w_to_hit;

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sel     <= 1'b0;
      r_blank   <= 1'b0;
      r_pending <= 1'b0;
      r_frm     <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_sel     <= w_sel_next;
      r_blank   <= w_blank_next;
      r_pending <= w_pending_next;
      r_frm     <= w_frm_next;
      r_to_cnt  <= w_to_next;
    end
  end

  // Next-state logic: swap on a watched vsync, count blanked frames,
  // queue at most one request while a swap is in flight.
  always_comb begin
    w_state_next   = r_state;
    w_sel_next     = r_sel;
    w_blank_next   = r_blank;
    w_pending_next = r_pending;
    w_frm_next     = r_frm;
    w_to_next      = '0;
    if (w_busy && !w_vs_ev) begin
      w_to_next = r_to_cnt + 1'b1;
    end
    case (r_state)
      S_IDLE: begin
        if (r_req || r_pending) begin
          w_state_next   = S_WAIT_VS;
          // Consuming the queued request while a new one arrives keeps the new one.
          w_pending_next = r_req && r_pending;
        end
      end
      S_WAIT_VS: begin
        if (r_req) w_pending_next = 1'b1;
        if (w_vs_ev) begin
          w_state_next = S_BLANK;
          w_sel_next   = ~r_sel;
          w_blank_next = 1'b1;
          w_frm_next   = '0;
        end
      end
      S_BLANK: begin
        if (r_req) w_pending_next = 1'b1;
        if (w_vs_ev) begin
          if (r_frm == FRM_W'(BLANK_FRAMES - 1)) begin
            w_state_next = S_IDLE;
            w_blank_next = 1'b0;
            w_frm_next   = '0;
          end else begin
            w_frm_next = r_frm + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign sel         = r_sel;
  assign blank       = r_blank;
  assign busy        = w_busy;
  assign req_pending = r_pending;

endmodule

// File: tb/tb_vga_source_switcher.sv
// Bench for vga_source_switcher: directed scenarios plus randomized traffic,
// every cycle compared against a sample-history reference model.
module tb_vga_source_switcher;

  localparam int DB  = 4;
  localparam int BF  = 2;
  localparam int TO  = 50;
  localparam bit VAL = 1'b1;
  localparam int VS_PERIOD = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic vgaV1 = 1'b1;
  logic vgaV2 = 1'b1;
  logic sel, blank, busy, req_pending;

  int n_tests = 0;
  int n_fail  = 0;

  vga_source_switcher #(
    .DEBOUNCE_CYCLES(DB),
    .BLANK_FRAMES(BF),
    .VS_TIMEOUT(TO),
    .VS_ACTIVE_LOW(VAL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .vgaV1(vgaV1),
    .vgaV2(vgaV2),
    .sel(sel),
    .blank(blank),
    .busy(busy),
    .req_pending(req_pending)
  );

  always #5 clk = ~clk;

  // Reference model: histories of pin samples (index k = sample k edges ago).
  bit h_btn[6];
  bit h_v1[4];
  bit h_v2[4];
  bit m_sel, m_blank, m_pend, m_deb, m_req_q;
  int m_phase;  // 0 idle, 1 waiting for vsync, 2 blanking
  int m_frm, m_to;

  // Vsync generators: mode 0 dead (held inactive), 1 periodic, 2 noise.
  int v1_mode = 1, v2_mode = 1;
  int cnt1 = 0, cnt2 = 7;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit vs_act(input bit x);
    return VAL ? !x : x;
  endfunction

  function automatic logic pick(input int which);
    case (which)
      0: return sel;
      1: return blank;
      2: return busy;
      default: return req_pending;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 6; k++) h_btn[k] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      h_v1[k] = VAL;
      h_v2[k] = VAL;
    end
    m_sel = 0; m_blank = 0; m_pend = 0; m_deb = 0; m_req_q = 0;
    m_phase = 0; m_frm = 0; m_to = 0;
  endtask

  task automatic model_edge();
    bit real_ev, ev, req, flip;
    int new_to;
    for (int k = 5; k > 0; k--) h_btn[k] = h_btn[k-1];
    for (int k = 3; k > 0; k--) begin
      h_v1[k] = h_v1[k-1];
      h_v2[k] = h_v2[k-1];
    end
    h_btn[0] = btn; h_v1[0] = vgaV1; h_v2[0] = vgaV2;
    // A start is the synced level becoming active, seen one edge later.
    real_ev = m_sel ? (vs_act(h_v2[2]) && !vs_act(h_v2[3]))
                    : (vs_act(h_v1[2]) && !vs_act(h_v1[3]));
    ev = (m_phase != 0) && (real_ev || (m_to == TO - 1));
    req = m_req_q;
    // Accepted level flips once the last DB synced samples all disagree with it.
    flip = 1'b1;
    for (int k = 2; k < 2 + DB; k++) if (h_btn[k] == m_deb) flip = 1'b0;
    m_req_q = flip && !m_deb;
    if (flip) m_deb = !m_deb;
    new_to = (m_phase != 0 && !ev) ? m_to + 1 : 0;
    if (m_phase == 0) begin
      if (req || m_pend) begin
        m_phase = 1;
        m_pend = req && m_pend;
      end
    end else if (m_phase == 1) begin
      if (req) m_pend = 1;
      if (ev) begin
        m_phase = 2; m_sel = !m_sel; m_blank = 1; m_frm = 0;
      end
    end else begin
      if (req) m_pend = 1;
      if (ev) begin
        m_frm++;
        if (m_frm == BF) begin
          m_phase = 0; m_blank = 0; m_frm = 0;
        end
      end
    end
    m_to = new_to;
  endtask

  task automatic drive_vs();
    cnt1 = (cnt1 + 1) % VS_PERIOD;
    cnt2 = (cnt2 + 1) % VS_PERIOD;
    case (v1_mode)
      0: vgaV1 = VAL;
      1: vgaV1 = (cnt1 < 2) ? !VAL : VAL;
      default: vgaV1 = ($urandom_range(0, 5) == 0) ? !VAL : VAL;
    endcase
    case (v2_mode)
      0: vgaV2 = VAL;
      1: vgaV2 = (cnt2 < 2) ? !VAL : VAL;
      default: vgaV2 = ($urandom_range(0, 5) == 0) ? !VAL : VAL;
    endcase
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_val("cyc_sel", sel, m_sel);
    check_val("cyc_blank", blank, m_blank);
    check_val("cyc_busy", busy, m_phase != 0);
    check_val("cyc_pend", req_pending, m_pend);
    drive_vs();
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      btn = 1'($urandom); vgaV1 = 1'($urandom); vgaV2 = 1'($urandom);
      #1;
      check_val("rst_sel", sel, 1'b0);
      check_val("rst_blank", blank, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_pend", req_pending, 1'b0);
    end
    btn = 1'b0;
    drive_vs();
    rst_n = 1'b1;
    $display("[TB] reset released t=%0t", $time);
  endtask

  task automatic press(input int hi, input int lo);
    $display("[TB] press hi=%0d lo=%0d sel=%0b busy=%0b pend=%0b", hi, lo, sel, busy, req_pending);
    btn = 1'b1;
    repeat (hi) tick();
    btn = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic wait_sig(input string tag, input int which, input logic val,
                          input int budget, output int n_out);
    logic cur;
    cur = pick(which);
    n_out = 0;
    while (cur !== val && n_out < budget) begin
      tick();
      n_out++;
      cur = pick(which);
    end
    check_val(tag, cur, val);
  endtask

  initial begin
    int n;
    model_reset();
    @(negedge clk);
    apply_reset(8);

    // Idle without button activity.
    repeat (30) tick();
    check_val("idle_busy", busy, 1'b0);

    // Bounce: runs too short to be accepted.
    btn = 1'b1; repeat (3) tick();
    btn = 1'b0; repeat (1) tick();
    btn = 1'b1; repeat (3) tick();
    btn = 1'b0; repeat (12) tick();
    check_val("bounce_busy", busy, 1'b0);
    check_val("bounce_pend", req_pending, 1'b0);

    // Clean hold: busy rises 2 sync + DB debounce + 1 FSM edges after the rise.
    btn = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check_val("deb_latency", n, 2 + DB + 1);
    btn = 1'b1; repeat (2) tick();
    btn = 1'b0;
    $display("[TB] swap requested latency=%0d", n);

    // Clean swap to source 2 and back out of blanking.
    wait_sig("swap_sel", 0, 1'b1, 60, n);
    check_val("swap_blank_on", blank, 1'b1);
    wait_sig("swap_unblank", 1, 1'b0, 80, n);
    check_val("swap_busy_off", busy, 1'b0);
    check_val("swap_sel_final", sel, 1'b1);
    $display("[TB] clean swap done sel=%0b", sel);
    repeat (10) tick();

    // Asynchronous reset while blanking.
    press(6, 6);
    wait_sig("midrst_blank", 1, 1'b1, 100, n);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_sel", sel, 1'b0);
    check_val("midrst_blank_off", blank, 1'b0);
    check_val("midrst_busy", busy, 1'b0);
    apply_reset(5);
    repeat (5) tick();
    check_val("midrst_idle", busy, 1'b0);

    // Queueing: one press starts a swap, two more arrive while busy.
    press(4, 4);
    press(4, 4);
    check_val("queue_pend", req_pending, 1'b1);
    press(4, 4);
    check_val("queue_pend_hold", req_pending, 1'b1);
    repeat (200) tick();
    check_val("queue_final_sel", sel, 1'b0);
    check_val("queue_final_busy", busy, 1'b0);
    check_val("queue_final_pend", req_pending, 1'b0);
    $display("[TB] queue test done sel=%0b", sel);

    // Dead source 2: blanking ends only through two timeouts.
    v2_mode = 0;
    press(5, 5);
    wait_sig("dead_blank_on", 1, 1'b1, 100, n);
    wait_sig("dead_blank_off", 1, 1'b0, 300, n);
    check_val("dead_blank_len", n, BF * TO);
    check_val("dead_busy", busy, 1'b0);
    check_val("dead_sel", sel, 1'b1);
    $display("[TB] dead source swap done blank_len=%0d", n);

    // Randomized traffic checked cycle by cycle against the model.
    v2_mode = 1;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0, 1: press($urandom_range(1, 8), $urandom_range(1, 8));
        2: repeat ($urandom_range(1, 40)) tick();
        default: begin
          v1_mode = $urandom_range(0, 2);
          v2_mode = $urandom_range(0, 2);
          $display("[TB] vsync modes v1=%0d v2=%0d", v1_mode, v2_mode);
          repeat (5) tick();
        end
      endcase
    end
    repeat (300) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
